snax_reshuffler_pipe: RTL

SNAX_RESHUFFLER_PIPE -- requirements
Module: snax_reshuffler_pipe

---
 rtl/snax_reshuffler_pkg.sv | 18 +
 rtl/snax_reshuffler_fifo.sv | 52 +++++
 rtl/snax_reshuffler_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/snax_reshuffler_pkg.sv
// Shared types for the reshuffler: transform modes, control FSM states and mode field width.
package snax_reshuffler_pkg;

  localparam int ModeWidth = 2;

  typedef enum logic [ModeWidth-1:0] {
    MODE_PASS      = 2'd0,
    MODE_TRANSPOSE = 2'd1,
    MODE_REVERSE   = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/snax_reshuffler_fifo.sv
// Small output buffer with wrap-around pointers; the head reads as zero whenever the buffer is empty.
module snax_reshuffler_fifo #(
  parameter int DataWidth = 512,
  parameter int Depth     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AddrWidth = $clog2(Depth);
  localparam logic [AddrWidth:0] PtrOne = 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrWidth:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrWidth:0]   rd_ptr_q, rd_ptr_d;
  logic                 push_en, pop_en;

  // The extra pointer MSB distinguishes full from empty when the addresses match.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
               (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);
    push_en  = push_i && !full_o;
    pop_en   = pop_i && !empty_o;
    wr_ptr_d = push_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + PtrOne : rd_ptr_q;
    data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AddrWidth-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AddrWidth-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/snax_reshuffler_pipe.sv
// Streaming tile reshuffler (passthrough / transpose / reverse) with a CSR job interface.
// Busy-cycle counter present only when SNAX_RESHUFFLER_PERF_CNT_EN is defined.
module snax_reshuffler_pipe
  import snax_reshuffler_pkg::*;
#(
  parameter int DataWidth = 512,
  parameter int ElemWidth = 8,
  parameter int TileDim   = 8,
  parameter int FifoDepth = 2,
  parameter int CntWidth  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DataWidth-1:0] io_data_input_i_bits,
  input  logic                 io_data_input_i_valid,
  output logic                 io_data_input_i_ready,
  output logic [DataWidth-1:0] io_data_output_o_bits,
  output logic                 io_data_output_o_valid,
  input  logic                 io_data_output_o_ready,
  input  logic [31:0]          io_ctrl_bits_0,
  input  logic [CntWidth-1:0]  io_ctrl_bits_1,
  input  logic                 io_ctrl_valid,
  output logic                 io_ctrl_ready,
  output logic [CntWidth-1:0]  io_performance_counter,
  output logic [31:0]          io_busy_o
);

  localparam int NumElem = TileDim * TileDim;
  localparam logic [CntWidth-1:0] CntOne = 1;

  if (DataWidth != TileDim * TileDim * ElemWidth) begin : g_bad_width
    $error("DataWidth must equal TileDim*TileDim*ElemWidth");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("FifoDepth must be a power of two and at least 2");
  end

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [CntWidth-1:0] beats_q, beats_d;
  logic [CntWidth-1:0] in_cnt_q, in_cnt_d;
  logic [CntWidth-1:0] out_cnt_q, out_cnt_d;
  logic                job_start;
  logic                fifo_full, fifo_empty;
  logic                in_fire, out_fire;
  logic [DataWidth-1:0] trans_w, rev_w, xform_w;
  logic                unused_ctrl_bits;

  assign unused_ctrl_bits = ^io_ctrl_bits_0[31:ModeWidth];

  // Element (r, c) of the input tile lands at (c, r) of the output tile.
  for (genvar gi = 0; gi < TileDim; gi++) begin : g_row
    for (genvar gj = 0; gj < TileDim; gj++) begin : g_col
      assign trans_w[(gj*TileDim+gi)*ElemWidth +: ElemWidth] =
             io_data_input_i_bits[(gi*TileDim+gj)*ElemWidth +: ElemWidth];
    end
  end

  for (genvar gi = 0; gi < NumElem; gi++) begin : g_rev
    assign rev_w[gi*ElemWidth +: ElemWidth] =
           io_data_input_i_bits[(NumElem-1-gi)*ElemWidth +: ElemWidth];
  end

  always_comb begin
    case (mode_q)
      MODE_TRANSPOSE: xform_w = trans_w;
      MODE_REVERSE:   xform_w = rev_w;
      default:        xform_w = io_data_input_i_bits;
    endcase
  end

  assign io_ctrl_ready          = (state_q == ST_IDLE);
  assign io_data_input_i_ready  = (state_q == ST_BUSY) && !fifo_full && (in_cnt_q < beats_q);
  assign io_data_output_o_valid = !fifo_empty;
  assign in_fire                = io_data_input_i_valid && io_data_input_i_ready;
  assign out_fire               = io_data_output_o_valid && io_data_output_o_ready;
  assign io_busy_o              = {31'b0, state_q == ST_BUSY};

  snax_reshuffler_fifo #(
    .DataWidth (DataWidth),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (in_fire),
    .data_i  (xform_w),
    .pop_i   (out_fire),
    .data_o  (io_data_output_o_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    beats_d   = beats_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    job_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io_ctrl_valid) begin
          job_start = 1'b1;
          mode_d    = mode_e'(io_ctrl_bits_0[ModeWidth-1:0]);
          beats_d   = io_ctrl_bits_1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          if (io_ctrl_bits_1 != '0) state_d = ST_BUSY;
        end
      end
      default: begin
        if (in_fire)  in_cnt_d  = in_cnt_q + CntOne;
        if (out_fire) out_cnt_d = out_cnt_q + CntOne;
        if (out_cnt_d == beats_q) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_PASS;
      beats_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      beats_q   <= beats_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef SNAX_RESHUFFLER_PERF_CNT_EN
  logic [CntWidth-1:0] perf_q, perf_d;

  // Saturating busy-cycle count; cleared only when a new job is accepted.
  always_comb begin
    perf_d = perf_q;
    if (job_start) begin
      perf_d = '0;
    end else if (state_q == ST_BUSY && perf_q != '1) begin
      perf_d = perf_q + CntOne;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign io_performance_counter = perf_q;
`else
  assign io_performance_counter = '0;
`endif

endmodule
